sram_arbiter: RTL and testbench

Two-port arbiter that shares the single SRAM controller between the instruction-fetch read port and the memory-stage cache port (refill reads and write-through writes). It sits between the requesters and the SRAM controller, replacing a point-to-point connection. It latches one request at a time, drives the controller's level-held read/write strobes until the controller reports ready, and returns a one-cycle acknowledge with registered read data to the winning port. Round-robin fairness is compile-time selectable.

---
 rtl/sram_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between the instruction read port and the data read/write port.
// Strobe rises one cycle after a grant; ack follows sram_ready by one cycle. Ties go to data, or round-robin with SRAM_ARB_RR_EN.
module sram_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int WDATA_W = 32,
   parameter int RDATA_W = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_req,
   input  logic [ADDR_W-1:0]  i_addr,
   output logic               i_ack,
   output logic [RDATA_W-1:0] i_rdata,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [ADDR_W-1:0]  d_addr,
   input  logic [WDATA_W-1:0] d_wdata,
   output logic               d_ack,
   output logic [RDATA_W-1:0] d_rdata,
   output logic               sram_read,
   output logic               sram_write,
   output logic [ADDR_W-1:0]  sram_address,
   output logic [WDATA_W-1:0] sram_wdata,
   input  logic [RDATA_W-1:0] sram_rdata,
   input  logic               sram_ready,
   output logic               busy,
   output logic               grant_d
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic               grant;
   logic               win_d;
   logic               we_q;
   logic               gnt_d_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [WDATA_W-1:0] wdata_q;
   logic [RDATA_W-1:0] i_rdata_q;
   logic [RDATA_W-1:0] d_rdata_q;

`ifdef SRAM_ARB_RR_EN
   // Remembers which port was granted last; reset value favours data on the first tie.
   logic last_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_d <= 1'b0;
      end else if (grant) begin
         last_d <= win_d;
      end
   end

   always_comb begin
      win_d = d_req & (~i_req | ~last_d);
   end
`else
   always_comb begin
      win_d = d_req;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      grant      = 1'b0;
      sram_read  = 1'b0;
      sram_write = 1'b0;
      i_ack      = 1'b0;
      d_ack      = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (i_req | d_req) begin
               grant     = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            busy       = 1'b1;
            sram_read  = ~we_q;
            sram_write = we_q;
            if (sram_ready) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            i_ack     = ~gnt_d_q;
            d_ack     = gnt_d_q;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request fields are captured once at grant; requester inputs are don't-care afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= 1'b0;
         gnt_d_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (grant) begin
         we_q    <= win_d & d_we;
         gnt_d_q <= win_d;
         addr_q  <= win_d ? d_addr : i_addr;
         wdata_q <= d_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else if (state == BUSY && sram_ready && !we_q) begin
         if (gnt_d_q) begin
            d_rdata_q <= sram_rdata;
         end else begin
            i_rdata_q <= sram_rdata;
         end
      end
   end

   assign sram_address = addr_q;
   assign sram_wdata   = wdata_q;
   assign i_rdata      = i_rdata_q;
   assign d_rdata      = d_rdata_q;
   assign grant_d      = gnt_d_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: the bench plays both requesters and the SRAM controller, with a transaction-level model.
`timescale 1ns/1ps
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_ack;
   logic [63:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ack;
   logic [63:0] d_rdata;
   logic        sram_read;
   logic        sram_write;
   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic [63:0] sram_rdata = '0;
   logic        sram_ready = 1'b0;
   logic        busy;
   logic        grant_d;

   always #5 clk = ~clk;

   sram_arbiter dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .sram_read(sram_read), .sram_write(sram_write), .sram_address(sram_address),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
      .busy(busy), .grant_d(grant_d)
   );

   int          checks = 0;
   int          failures = 0;
   logic [63:0] exp_i_rdata = '0;
   logic [63:0] exp_d_rdata = '0;
   logic        last_d_m = 1'b0;
   logic        wd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rdata(input string tag);
      chk({tag, ":i_rdata"}, i_rdata, exp_i_rdata);
      chk({tag, ":d_rdata"}, d_rdata, exp_d_rdata);
   endtask

   // One granted transaction, entered while idle with requests set up for the next edge; leaves in DONE.
   task automatic txn(input int lat, input logic [63:0] rd, output logic win);
      logic        we;
      logic [31:0] a;
      logic [31:0] wdat;
      if (i_req && d_req) begin
`ifdef SRAM_ARB_RR_EN
         win = ~last_d_m;
`else
         win = 1'b1;
`endif
      end else begin
         win = d_req;
      end
      last_d_m   = win;
      we         = win & d_we;
      a          = win ? d_addr : i_addr;
      wdat       = d_wdata;
      sram_ready = 1'b0;
      step();
      chk("busy_on_grant", 64'(busy), 64'd1);
      chk("grant_d", 64'(grant_d), 64'(win));
      chk("strobe_first", 64'({sram_read, sram_write}), we ? 64'd1 : 64'd2);
      chk("address", 64'(sram_address), 64'(a));
      if (we) chk("wdata", 64'(sram_wdata), 64'(wdat));
      chk("ack_in_busy", 64'({i_ack, d_ack}), 64'd0);
      for (int k = 0; k < lat; k++) begin
         step();
         chk("strobe_hold", 64'({sram_read, sram_write}), we ? 64'd1 : 64'd2);
      end
      sram_ready = 1'b1;
      sram_rdata = rd;
      step();
      sram_ready = 1'b0;
      if (!we) begin
         if (win) exp_d_rdata = rd;
         else     exp_i_rdata = rd;
      end
      chk("done_busy", 64'(busy), 64'd1);
      chk("done_strobes", 64'({sram_read, sram_write}), 64'd0);
      chk("i_ack", 64'(i_ack), 64'(!win));
      chk("d_ack", 64'(d_ack), 64'(win));
      chk_rdata("done");
      if (win) d_req = 1'b0;
      else     i_req = 1'b0;
   endtask

   // One cycle into (or staying in) IDLE; spur drives a ready pulse that must be ignored.
   task automatic to_idle(input logic spur);
      sram_ready = spur;
      sram_rdata = {$urandom, $urandom};
      step();
      sram_ready = 1'b0;
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_strobes", 64'({sram_read, sram_write}), 64'd0);
      chk("idle_acks", 64'({i_ack, d_ack}), 64'd0);
      chk_rdata("idle");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_strobes", 64'({sram_read, sram_write}), 64'd0);
      chk("rst_acks", 64'({i_ack, d_ack}), 64'd0);
      chk("rst_busy_grant", 64'({busy, grant_d}), 64'd0);
      chk("rst_address", 64'(sram_address), 64'd0);
      chk("rst_wdata", 64'(sram_wdata), 64'd0);
      chk_rdata("rst");
      @(negedge clk);
      rst = 1'b1;
      step();

      // single instruction read: strobe cycles 1..5, ready in cycle 5, ack in cycle 6
      i_req  = 1'b1;
      i_addr = 32'h100;
      txn(4, 64'h1122334455667788, wd);
      chk("t1_winner", 64'(wd), 64'd0);
      chk("t1_rdata", i_rdata, 64'h1122334455667788);
      to_idle(1'b0);

      // data read then data write: write leaves d_rdata alone
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h80;
      txn(2, {$urandom, $urandom}, wd);
      to_idle(1'b0);
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h40;
      d_wdata = 32'hDEADBEEF;
      txn(3, {$urandom, $urandom}, wd);

      // back-to-back data reads: exactly DONE + IDLE low between strobes
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h200;
      to_idle(1'b0);
      txn(1, {$urandom, $urandom}, wd);
      d_req  = 1'b1;
      d_addr = 32'h208;
      to_idle(1'b0);
      txn(0, {$urandom, $urandom}, wd);
      to_idle(1'b0);

      // spurious ready while idle
      to_idle(1'b1);
      to_idle(1'b1);

      // reset during BUSY
      i_req  = 1'b1;
      i_addr = 32'h300;
      step();
      chk("pre_rst_read", 64'(sram_read), 64'd1);
      step();
      #2;
      rst = 1'b0;
      #1;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      last_d_m    = 1'b0;
      chk("mid_rst_strobes", 64'({sram_read, sram_write}), 64'd0);
      chk("mid_rst_acks", 64'({i_ack, d_ack}), 64'd0);
      chk("mid_rst_busy_grant", 64'({busy, grant_d}), 64'd0);
      chk("mid_rst_address", 64'(sram_address), 64'd0);
      chk_rdata("mid_rst");
      i_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      to_idle(1'b0);
      i_req  = 1'b1;
      i_addr = 32'h304;
      txn(2, {$urandom, $urandom}, wd);
      chk("post_rst_winner", 64'(wd), 64'd0);
      to_idle(1'b0);

      // simultaneous requests held continuously
      i_req  = 1'b1;
      d_req  = 1'b1;
      d_we   = 1'b0;
      i_addr = 32'h400;
      d_addr = 32'h500;
      for (int k = 0; k < 4; k++) begin
         txn(1, {$urandom, $urandom}, wd);
`ifdef SRAM_ARB_RR_EN
         chk("tie_grant", 64'(wd), (k % 2 == 0) ? 64'd1 : 64'd0);
`else
         chk("tie_grant", 64'(wd), 64'd1);
`endif
         if (wd) d_addr = d_addr + 32'h8;
         else    i_addr = i_addr + 32'h4;
         i_req = 1'b1;
         d_req = 1'b1;
         to_idle(1'b0);
      end

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         txn(int'($urandom_range(0, 4)), {$urandom, $urandom}, wd);
         if (!i_req && 1'($urandom_range(0, 1))) begin
            i_req  = 1'b1;
            i_addr = $urandom;
         end
         if (!d_req && 1'($urandom_range(0, 1))) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom;
            d_wdata = $urandom;
         end
         to_idle(1'($urandom_range(0, 1)));
         if (!i_req && !d_req) begin
            to_idle(1'($urandom_range(0, 1)));
            if (1'($urandom_range(0, 1))) begin
               i_req  = 1'b1;
               i_addr = $urandom;
            end else begin
               d_req   = 1'b1;
               d_we    = 1'($urandom_range(0, 1));
               d_addr  = $urandom;
               d_wdata = $urandom;
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
